fab_selftest_ctrl: RTL and testbench
====================================

FAB_SELFTEST_CTRL -- requirements
Module: fab_selftest_ctrl

Interface
REQ-001 SHALL have parameter IO_WIDTH, default 28, width of fabric user I/O vectors.
REQ-002 SHALL have parameter WORD_BYTES, default 4, bitstream bytes packed per config write word.
REQ-003 SHALL have parameter MAX_BITBYTES, default 32768, bitstream length in bytes; SHALL be a multiple of WORD_BYTES.
REQ-004 SHALL have parameters SETUP_CYCLES, default 2; GAP_CYCLES, default 2; SETTLE_CYCLES, default 100; URST_CYCLES, default 5; CHECK_CYCLES, default 100; each SHALL be at least 1.
REQ-005 SHALL have ports: CLK  in  1  single clock; reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have ports: start  in  1  begin sequence pulse; busy  out  1; done  out  1; pass  out  1.
REQ-007 SHALL have ports: bs_rd  out  1  byte read request; bs_addr  out  clog2(MAX_BITBYTES)  byte address; bs_data  in  8  byte, valid one cycle after bs_rd.
REQ-008 SHALL have ports: SelfWriteData  out  8*WORD_BYTES  config word; SelfWriteStrobe  out  1  config write pulse.
REQ-009 SHALL have ports: O_top  out  IO_WIDTH  stimulus to fabric and gold; I_top, T_top, I_gold, T_gold  in  IO_WIDTH each.
REQ-010 SHALL have ports: err_count  out  16; first_err_cycle  out  16; first_err_mask  out  IO_WIDTH.

Function
REQ-011 SHALL implement states IDLE, FETCH, SETUP, STROBE, GAP, SETTLE, URST, CHECK, DONE.
REQ-012 IDLE: start=1 SHALL enter FETCH next cycle with byte address 0 and err_count, first_err_* cleared; busy=1 in all states except IDLE and DONE.
REQ-013 FETCH: bs_rd SHALL be high for WORD_BYTES consecutive cycles at consecutive addresses; each bs_data SHALL be captured the following cycle; FETCH lasts WORD_BYTES+1 cycles.
REQ-014 Packing: first byte of a word SHALL occupy SelfWriteData[8*WORD_BYTES-1 -: 8], later bytes descending (big-endian).
REQ-015 SETUP SHALL hold SelfWriteData stable SETUP_CYCLES cycles; STROBE SHALL assert SelfWriteStrobe exactly one cycle; GAP SHALL last GAP_CYCLES cycles with strobe low.
REQ-016 After GAP: next FETCH if words remain, else SETTLE; exactly MAX_BITBYTES/WORD_BYTES strobes SHALL occur, bs_addr never exceeding MAX_BITBYTES-1.
REQ-017 SelfWriteData SHALL hold its last value outside SETUP/STROBE/GAP until the next FETCH completes.
REQ-018 SETTLE SHALL last SETTLE_CYCLES with O_top=0; URST SHALL drive O_top=1 (bit 0 only) for URST_CYCLES; CHECK SHALL drive O_top=0.
REQ-019 CHECK SHALL last CHECK_CYCLES cycles; each cycle mismatch mask = (I_top^I_gold)|(T_top^T_gold), sampled at the clock edge.
REQ-020 On nonzero mask err_count SHALL increment, saturating at 16'hFFFF.
REQ-021 On the first nonzero mask: first_err_cycle SHALL capture the CHECK cycle index (0-based), first_err_mask the mask; later mismatches SHALL not overwrite them.
REQ-022 DONE: done=1, pass=(err_count==0); outputs held until start; start in DONE SHALL behave as in IDLE.
REQ-023 start while busy SHALL be ignored.
REQ-024 pass SHALL be 0 whenever done=0.

Reset
REQ-025 reset=1 SHALL, at the next CLK edge, force IDLE and busy=0, done=0, pass=0, bs_rd=0, bs_addr=0, SelfWriteStrobe=0, SelfWriteData=0, O_top=0, err_count=0, first_err_cycle=0, first_err_mask=0, regardless of state (including mid-FETCH or STROBE).
REQ-026 reset SHALL take priority over start in the same cycle.

Verification
REQ-027 WORD_BYTES=4, MAX_BITBYTES=8, bytes 00..07 -> two strobes, words 0x00010203 then 0x04050607, each stable SETUP_CYCLES before strobe, strobe width 1.
REQ-028 Gold inputs tied equal to fabric inputs throughout -> done=1, pass=1, err_count=0 after exactly 2*(WORD_BYTES+1+SETUP+1+GAP)+SETTLE+URST+CHECK cycles.
REQ-029 I_top bit 3 differs from I_gold on CHECK cycles 7 and 9 -> err_count=2, first_err_cycle=7, first_err_mask=0x0000008, pass=0.
REQ-030 reset asserted during second STROBE -> next cycle SelfWriteStrobe=0, busy=0, all outputs at reset values; new start restarts at bs_addr=0.
REQ-031 CHECK_CYCLES=70000, constant mismatch -> err_count saturates at 0xFFFF, no wrap.
REQ-032 start pulsed during FETCH and CHECK -> no restart, strobe count and err_count unaffected.

Source files
------------

// File: rtl/fab_selftest_ctrl.sv
// Fabric self-test sequencer: streams a bitstream into config words, pulses the
// user reset, then compares fabric I/O against a gold model for a fixed window.
module fab_selftest_ctrl #(
  parameter int IO_WIDTH      = 28,
  parameter int WORD_BYTES    = 4,
  parameter int MAX_BITBYTES  = 32768,
  parameter int SETUP_CYCLES  = 2,
  parameter int GAP_CYCLES    = 2,
  parameter int SETTLE_CYCLES = 100,
  parameter int URST_CYCLES   = 5,
  parameter int CHECK_CYCLES  = 100
) (
  input  logic                             CLK,
  input  logic                             reset,
  input  logic                             start,
  output logic                             busy,
  output logic                             done,
  output logic                             pass,
  output logic                             bs_rd,
  output logic [$clog2(MAX_BITBYTES)-1:0]  bs_addr,
  input  logic [7:0]                       bs_data,
  output logic [8*WORD_BYTES-1:0]          SelfWriteData,
  output logic                             SelfWriteStrobe,
  output logic [IO_WIDTH-1:0]              O_top,
  input  logic [IO_WIDTH-1:0]              I_top,
  input  logic [IO_WIDTH-1:0]              T_top,
  input  logic [IO_WIDTH-1:0]              I_gold,
  input  logic [IO_WIDTH-1:0]              T_gold,
  output logic [15:0]                      err_count,
  output logic [15:0]                      first_err_cycle,
  output logic [IO_WIDTH-1:0]              first_err_mask
);

  // state  | meaning
  // IDLE   | waiting for start
  // FETCH  | read WORD_BYTES bytes, pack into config word
  // SETUP  | config word stable before strobe
  // STROBE | one-cycle config write pulse
  // GAP    | strobe low; next word or settle
  // SETTLE | fabric settles, O_top = 0
  // URST   | O_top bit 0 held high (user reset)
  // CHECK  | compare fabric vs gold each cycle
  // DONE   | results held until start
  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_SETUP, S_STROBE, S_GAP, S_SETTLE, S_URST, S_CHECK, S_DONE
  } state_t;

  localparam int AW = $clog2(MAX_BITBYTES);
  localparam int DW = 8 * WORD_BYTES;
  localparam logic [AW-1:0] LAST_ADDR = AW'(MAX_BITBYTES - 1);

  state_t                state_q, state_d;
  logic [31:0]           tmr_q, tmr_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic                  last_q, last_d;
  logic [DW-1:0]         pack_q, pack_d, wdata_q, wdata_d;
  logic [15:0]           err_q, err_d, ferr_cyc_q, ferr_cyc_d;
  logic [IO_WIDTH-1:0]   ferr_mask_q, ferr_mask_d, mismatch;
  logic [15:0]           chk_idx;

  assign mismatch = (I_top ^ I_gold) | (T_top ^ T_gold);
  // timer counts down, so the 0-based CHECK index is its distance from the top
  assign chk_idx  = 16'(32'(CHECK_CYCLES - 1) - tmr_q);

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q     <= S_IDLE;
      tmr_q       <= '0;
      addr_q      <= '0;
      last_q      <= 1'b0;
      pack_q      <= '0;
      wdata_q     <= '0;
      err_q       <= '0;
      ferr_cyc_q  <= '0;
      ferr_mask_q <= '0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      addr_q      <= addr_d;
      last_q      <= last_d;
      pack_q      <= pack_d;
      wdata_q     <= wdata_d;
      err_q       <= err_d;
      ferr_cyc_q  <= ferr_cyc_d;
      ferr_mask_q <= ferr_mask_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    tmr_d           = tmr_q;
    addr_d          = addr_q;
    last_d          = last_q;
    pack_d          = pack_q;
    wdata_d         = wdata_q;
    err_d           = err_q;
    ferr_cyc_d      = ferr_cyc_q;
    ferr_mask_d     = ferr_mask_q;
    busy            = 1'b1;
    done            = 1'b0;
    pass            = 1'b0;
    bs_rd           = 1'b0;
    SelfWriteStrobe = 1'b0;
    O_top           = '0;

    case (state_q)
      S_IDLE: busy = 1'b0;
      S_DONE: begin
        busy = 1'b0;
        done = 1'b1;
        pass = (err_q == 16'd0);
      end
      S_FETCH: begin
        bs_rd = (tmr_q != 32'd0);
        if (bs_rd) begin
          // park on the final byte so the address never leaves the bitstream
          if (addr_q == LAST_ADDR) last_d = 1'b1;
          else                     addr_d = addr_q + AW'(1);
        end
        if (tmr_q != 32'(WORD_BYTES)) pack_d = (pack_q << 8) | DW'(bs_data);
        if (tmr_q == 32'd0) begin
          state_d = S_SETUP;
          tmr_d   = 32'(SETUP_CYCLES - 1);
          wdata_d = pack_d;
        end else begin
          tmr_d = tmr_q - 32'd1;
        end
      end
      S_SETUP: begin
        if (tmr_q == 32'd0) state_d = S_STROBE;
        else                tmr_d   = tmr_q - 32'd1;
      end
      S_STROBE: begin
        SelfWriteStrobe = 1'b1;
        state_d         = S_GAP;
        tmr_d           = 32'(GAP_CYCLES - 1);
      end
      S_GAP: begin
        if (tmr_q != 32'd0) begin
          tmr_d = tmr_q - 32'd1;
        end else if (last_q) begin
          state_d = S_SETTLE;
          tmr_d   = 32'(SETTLE_CYCLES - 1);
        end else begin
          state_d = S_FETCH;
          tmr_d   = 32'(WORD_BYTES);
        end
      end
      S_SETTLE: begin
        if (tmr_q == 32'd0) begin
          state_d = S_URST;
          tmr_d   = 32'(URST_CYCLES - 1);
        end else begin
          tmr_d = tmr_q - 32'd1;
        end
      end
      S_URST: begin
        O_top = IO_WIDTH'(1);
        if (tmr_q == 32'd0) begin
          state_d = S_CHECK;
          tmr_d   = 32'(CHECK_CYCLES - 1);
        end else begin
          tmr_d = tmr_q - 32'd1;
        end
      end
      S_CHECK: begin
        if (mismatch != '0) begin
          if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
          if (err_q == 16'd0) begin
            ferr_cyc_d  = chk_idx;
            ferr_mask_d = mismatch;
          end
        end
        if (tmr_q == 32'd0) state_d = S_DONE;
        else                tmr_d   = tmr_q - 32'd1;
      end
      default: state_d = S_IDLE;
    endcase

    if ((state_q == S_IDLE || state_q == S_DONE) && start) begin
      state_d     = S_FETCH;
      tmr_d       = 32'(WORD_BYTES);
      addr_d      = '0;
      last_d      = 1'b0;
      err_d       = '0;
      ferr_cyc_d  = '0;
      ferr_mask_d = '0;
    end
  end

  assign bs_addr         = addr_q;
  assign SelfWriteData   = wdata_q;
  assign err_count       = err_q;
  assign first_err_cycle = ferr_cyc_q;
  assign first_err_mask  = ferr_mask_q;

endmodule

// File: tb/tb_fab_selftest_ctrl.sv
// Randomised bench for fab_selftest_ctrl with a cycle-level timing model; a
// second instance runs a long CHECK window to exercise error-count saturation.
module tb_fab_selftest_ctrl;
  localparam int IOW = 28;
  localparam int WB  = 4;
  localparam int MB  = 8;
  localparam int SU  = 2;
  localparam int GP  = 2;
  localparam int ST  = 100;
  localparam int UR  = 5;
  localparam int CK  = 100;
  localparam int NW  = MB / WB;
  localparam int WP  = WB + 1 + SU + 1 + GP;
  localparam int P   = NW * WP + ST + UR;
  localparam int N   = P + CK;
  localparam int SAT_CK = 70000;

  logic              clk = 1'b0;
  logic              reset, start, busy, done, pass, bs_rd, sws;
  logic [2:0]        bs_addr;
  logic [7:0]        bs_data;
  logic [8*WB-1:0]   swd;
  logic [IOW-1:0]    o_top, i_top, t_top, i_gold, t_gold, first_err_mask;
  logic [15:0]       err_count, first_err_cycle;

  logic              reset2, start2, busy2, done2, pass2, bs_rd2, sws2;
  logic [1:0]        bs_addr2;
  logic [31:0]       swd2;
  logic [IOW-1:0]    o_top2, i_top2, t_top2, i_gold2, t_gold2, fm2;
  logic [15:0]       err2, fc2;

  logic [7:0]        mem [MB];
  logic [IOW-1:0]    mm_i [CK];
  logic [IOW-1:0]    mm_t [CK];
  logic [8*WB-1:0]   prev_word;
  int                n_checks = 0;
  int                n_errors = 0;
  bit                sat_done = 1'b0;

  always #5 clk = ~clk;

  fab_selftest_ctrl #(
    .IO_WIDTH(IOW), .WORD_BYTES(WB), .MAX_BITBYTES(MB), .SETUP_CYCLES(SU),
    .GAP_CYCLES(GP), .SETTLE_CYCLES(ST), .URST_CYCLES(UR), .CHECK_CYCLES(CK)
  ) u_dut (
    .CLK(clk), .reset(reset), .start(start), .busy(busy), .done(done), .pass(pass),
    .bs_rd(bs_rd), .bs_addr(bs_addr), .bs_data(bs_data),
    .SelfWriteData(swd), .SelfWriteStrobe(sws), .O_top(o_top),
    .I_top(i_top), .T_top(t_top), .I_gold(i_gold), .T_gold(t_gold),
    .err_count(err_count), .first_err_cycle(first_err_cycle), .first_err_mask(first_err_mask)
  );

  fab_selftest_ctrl #(
    .IO_WIDTH(IOW), .WORD_BYTES(4), .MAX_BITBYTES(4), .SETUP_CYCLES(1),
    .GAP_CYCLES(1), .SETTLE_CYCLES(1), .URST_CYCLES(1), .CHECK_CYCLES(SAT_CK)
  ) u_sat (
    .CLK(clk), .reset(reset2), .start(start2), .busy(busy2), .done(done2), .pass(pass2),
    .bs_rd(bs_rd2), .bs_addr(bs_addr2), .bs_data(8'h5A),
    .SelfWriteData(swd2), .SelfWriteStrobe(sws2), .O_top(o_top2),
    .I_top(i_top2), .T_top(t_top2), .I_gold(i_gold2), .T_gold(t_gold2),
    .err_count(err2), .first_err_cycle(fc2), .first_err_mask(fm2)
  );

  // bitstream memory: one-cycle read latency
  always @(posedge clk) if (bs_rd) bs_data <= mem[bs_addr];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [8*WB-1:0] word_of(input int w);
    logic [8*WB-1:0] v;
    v = '0;
    for (int b = 0; b < WB; b++) v = (v << 8) | (8*WB)'(mem[w*WB+b]);
    return v;
  endfunction

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_busy"}, 64'(busy), 64'(0));
    check_val({tag, "_done"}, 64'(done), 64'(0));
    check_val({tag, "_pass"}, 64'(pass), 64'(0));
    check_val({tag, "_bs_rd"}, 64'(bs_rd), 64'(0));
    check_val({tag, "_bs_addr"}, 64'(bs_addr), 64'(0));
    check_val({tag, "_strobe"}, 64'(sws), 64'(0));
    check_val({tag, "_wdata"}, 64'(swd), 64'(0));
    check_val({tag, "_o_top"}, 64'(o_top), 64'(0));
    check_val({tag, "_err"}, 64'(err_count), 64'(0));
    check_val({tag, "_fcyc"}, 64'(first_err_cycle), 64'(0));
    check_val({tag, "_fmask"}, 64'(first_err_mask), 64'(0));
  endtask

  task automatic gen_mm(input int pct);
    logic [31:0] rnd;
    for (int j = 0; j < CK; j++) begin
      mm_i[j] = '0;
      mm_t[j] = '0;
      if ($urandom_range(0, 99) < pct) begin
        rnd = $urandom;
        mm_i[j] = rnd[IOW-1:0] & {IOW{rnd[31]}};
        rnd = $urandom;
        mm_t[j] = rnd[IOW-1:0] & {IOW{rnd[30]}};
        if ((mm_i[j] | mm_t[j]) == '0) mm_i[j][$urandom_range(0, IOW-1)] = 1'b1;
      end
    end
  endtask

  task automatic drive_io(input bit in_check, input int j);
    logic [31:0] rnd;
    rnd = $urandom; i_gold = rnd[IOW-1:0];
    rnd = $urandom; t_gold = rnd[IOW-1:0];
    if (in_check) begin
      i_top = i_gold ^ mm_i[j];
      t_top = t_gold ^ mm_t[j];
    end else begin
      rnd = $urandom; i_top = i_gold ^ (rnd[IOW-1:0] & {IOW{rnd[31]}});
      rnd = $urandom; t_top = t_gold ^ (rnd[IOW-1:0] & {IOW{rnd[31]}});
    end
  endtask

  // One full sequence from the current idle/done state; abort_t > 0 asserts
  // reset during that cycle instead of running to completion.
  task automatic run_seq(input bit inject, input int abort_t);
    int exp_err, exp_first, w, r;
    logic [IOW-1:0] exp_mask, m;
    logic [8*WB-1:0] last_w;
    exp_err = 0; exp_first = 0; exp_mask = '0;
    for (int j = 0; j < CK; j++) begin
      m = mm_i[j] | mm_t[j];
      if (m != '0) begin
        if (exp_err == 0) begin exp_first = j; exp_mask = m; end
        exp_err++;
      end
    end
    last_w = word_of(NW - 1);
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    for (int t = 1; t <= N + 3; t++) begin
      @(negedge clk);
      start = inject && (t == 2 || t == P + 3);
      if (t <= N) begin
        check_val("busy", 64'(busy), 64'(1));
        check_val("done_early", 64'(done), 64'(0));
        check_val("pass_early", 64'(pass), 64'(0));
        if (t <= NW * WP) begin
          w = (t - 1) / WP;
          r = (t - 1) % WP;
          check_val("bs_rd", 64'(bs_rd), 64'(r < WB));
          if (r < WB) check_val("bs_addr", 64'(bs_addr), 64'(w * WB + r));
          check_val("strobe", 64'(sws), 64'(r == WB + 1 + SU));
          if (r > WB) check_val("wdata", 64'(swd), 64'(word_of(w)));
          else check_val("wdata_hold", 64'(swd), 64'((w == 0) ? prev_word : word_of(w - 1)));
          check_val("o_top_load", 64'(o_top), 64'(0));
        end else begin
          check_val("bs_rd_idle", 64'(bs_rd), 64'(0));
          check_val("strobe_idle", 64'(sws), 64'(0));
          check_val("wdata_last", 64'(swd), 64'(last_w));
          check_val("o_top", 64'(o_top), 64'((t > NW * WP + ST && t <= P) ? 1 : 0));
        end
      end else begin
        check_val("busy_done", 64'(busy), 64'(0));
        check_val("done", 64'(done), 64'(1));
        check_val("pass", 64'(pass), 64'(exp_err == 0));
        check_val("err_count", 64'(err_count), 64'(exp_err));
        check_val("first_err_cycle", 64'(first_err_cycle), 64'(exp_first));
        check_val("first_err_mask", 64'(first_err_mask), 64'(exp_mask));
        check_val("o_top_done", 64'(o_top), 64'(0));
      end
      if (t == abort_t) begin
        reset = 1'b1;
        @(negedge clk);
        check_reset_vals("abort");
        reset = 1'b0;
        prev_word = '0;
        return;
      end
      drive_io(t > P && t <= N, t - P - 1);
    end
    prev_word = last_w;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0;
    i_top = '0; t_top = '0; i_gold = '0; t_gold = '0;
    prev_word = '0;
    for (int i = 0; i < MB; i++) mem[i] = 8'(i);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("por");
    reset = 1'b0;

    gen_mm(0);
    run_seq(1'b0, 0);

    for (int j = 0; j < CK; j++) begin mm_i[j] = '0; mm_t[j] = '0; end
    mm_i[7] = IOW'(8);
    mm_i[9] = IOW'(8);
    run_seq(1'b0, 0);

    gen_mm(0);
    run_seq(1'b1, 0);

    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < MB; i++) mem[i] = 8'($urandom);
      case (k)
        0: gen_mm(5);
        1: gen_mm(40);
        2: gen_mm(100);
        default: gen_mm(int'($urandom_range(0, 20)));
      endcase
      run_seq(k[0], 0);
    end

    gen_mm(10);
    run_seq(1'b0, WP + WB + 1 + SU + 1);
    for (int i = 0; i < MB; i++) mem[i] = 8'($urandom);
    gen_mm(10);
    run_seq(1'b0, 0);

    @(negedge clk);
    reset = 1'b1; start = 1'b1;
    @(negedge clk);
    check_reset_vals("rst_vs_start");
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    check_val("idle_after_rst", 64'(busy), 64'(0));

    for (int c = 0; c < 100000 && !sat_done; c++) @(negedge clk);
    check_val("sat_join", 64'(sat_done), 64'(1));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    int cnt;
    reset2 = 1'b1; start2 = 1'b0;
    i_gold2 = '0; t_gold2 = '0; i_top2 = '1; t_top2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset2 = 1'b0; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    cnt = 0;
    while (!done2 && cnt < SAT_CK + 1000) begin
      @(negedge clk);
      cnt++;
    end
    check_val("sat_timeout", 64'(done2), 64'(1));
    check_val("sat_err", 64'(err2), 64'(16'hFFFF));
    check_val("sat_first_cycle", 64'(fc2), 64'(0));
    check_val("sat_first_mask", 64'(fm2), 64'({IOW{1'b1}}));
    check_val("sat_pass", 64'(pass2), 64'(0));
    sat_done = 1'b1;
  end
endmodule
